regfile_wb_arbiter: RTL and testbench
=====================================

REGFILE_WB_ARBITER -- requirements
Module: regfile_wb_arbiter

Interface
REQ-001 Parameters SHALL be: N, 5, register address bits; WIDTH, 32, data bits; NREQ, 3, number of writeback requesters.
REQ-002 Port: clk  input  1  single clock; all state on rising edge.
REQ-003 Port: rst  input  1  reset, asynchronous, active-low (asserted when 0).
REQ-004 Port: req_valid  input  NREQ  requester i holds a write.
REQ-005 Port: req_ready  output  NREQ  one-hot grant; transfer when valid&ready.
REQ-006 Port: req_reg  input  NREQ x N  destination register per requester.
REQ-007 Port: req_data  input  NREQ x WIDTH  write data per requester.
REQ-008 Port: rf_wenable / rf_reg / rf_din  output  1 / N / WIDTH  register file write port.
REQ-009 Port: iss_valid, iss_reg  input  1, N  issue stage marks iss_reg as pending producer.
REQ-010 Port: pending  output  2**N  scoreboard, bit r = write to r outstanding.

Function
REQ-011 Arbiter SHALL grant at most one requester per cycle, req_ready combinational from req_valid and priority pointer.
REQ-012 Priority SHALL be round-robin: search starts at last granted index + 1, modulo NREQ.
REQ-013 Pointer SHALL update only on a transfer; no transfer leaves pointer unchanged.
REQ-014 req_ready[i] SHALL never be high while req_valid[i] is low.
REQ-015 Requester SHALL hold valid, reg, data stable until granted; arbiter SHALL not rely on deassertion.
REQ-016 Output stage SHALL be registered: transfer in cycle t drives rf_wenable=1, rf_reg, rf_din in cycle t+1 for exactly one cycle.
REQ-017 Throughput SHALL be one write per cycle; output stage never back-pressures.
REQ-018 No transfer in cycle t SHALL give rf_wenable=0 in t+1; rf_reg/rf_din hold last value.
REQ-019 Transfer with req_reg=0 SHALL be accepted (ready high) but rf_wenable SHALL stay 0 in t+1.
REQ-020 iss_valid with iss_reg r!=0 SHALL set pending[r] at next edge; iss_reg=0 ignored, pending[0] always 0.
REQ-021 rf_wenable=1 for register r SHALL clear pending[r] at the same edge that ends the write cycle.
REQ-022 Set and clear of the same r in one cycle: set SHALL win (newer producer outstanding).
REQ-023 Set and clear of different registers in one cycle SHALL both take effect.
REQ-024 Two requesters targeting the same register SHALL be serialized in grant order; last write wins in the register file.

Reset
REQ-025 rst=0 SHALL immediately clear rf_wenable, rf_reg, rf_din, pending to 0, independent of clk.
REQ-026 Reset SHALL set pointer to NREQ-1 so requester 0 has highest priority first.
REQ-027 req_ready SHALL be 0 while rst=0; a write in flight at reset SHALL be dropped.
REQ-028 First transfer SHALL be possible on the first rising edge after rst deasserts.

Structure
REQ-029 Package regfile_pkg SHALL hold N, WIDTH, NREQ defaults and typedefs reg_addr_t, reg_data_t.
REQ-030 Round-robin grant logic SHALL be a sub-module rr_arbiter (parameter NREQ; inputs valid, pointer; output one-hot grant).
REQ-031 Block SHALL connect directly to register_file write port (wenable, reg_in, din) with no glue logic.

Verification
REQ-032 After reset, all three valid with regs 1,2,3 held: grants 0,1,2 on consecutive cycles; rf_wenable high three cycles writing 1,2,3, each one cycle after grant.
REQ-033 Req 1 valid alone for 4 cycles (new data each transfer): granted every cycle, pointer stays 1; then all valid: next grant is 2.
REQ-034 Req 0 writes reg 0 data 0xDEADBEEF: req_ready[0]=1, rf_wenable stays 0, pending unchanged.
REQ-035 iss_valid reg 5; later req 2 writes reg 5: pending[5]=1 until rf_wenable cycle, 0 after; same-cycle reissue of reg 5 leaves pending[5]=1.
REQ-036 rst pulled low mid-cycle while rf_wenable=1 and pending=0x00000024: outputs and pending 0 before next edge; after release requester 0 granted first.

Source files
------------

// File: rtl/regfile_pkg.sv
// Shared sizing defaults and data types for the register-file writeback path.
package regfile_pkg;

    localparam int N     = 5;
    localparam int WIDTH = 32;
    localparam int NREQ  = 3;

    typedef logic [N-1:0]     reg_addr_t;
    typedef logic [WIDTH-1:0] reg_data_t;

    // Width of a requester index, kept at least one bit so a single requester still elaborates
    function automatic int ptr_width(input int nreq);
        return (nreq > 1) ? $clog2(nreq) : 1;
    endfunction

endpackage

// File: rtl/regfile_wb_arbiter_if.sv
// Writeback bus: requester handshakes, issue-stage marks, register-file write port
// and the pending scoreboard, seen from the requester side (master) and the arbiter (slave).
interface regfile_wb_arbiter_if #(
    parameter int N     = regfile_pkg::N,
    parameter int WIDTH = regfile_pkg::WIDTH,
    parameter int NREQ  = regfile_pkg::NREQ
);
    logic [NREQ-1:0]            req_valid;
    logic [NREQ-1:0]            req_ready;
    logic [NREQ-1:0][N-1:0]     req_reg;
    logic [NREQ-1:0][WIDTH-1:0] req_data;

    logic                       rf_wenable;
    logic [N-1:0]               rf_reg;
    logic [WIDTH-1:0]           rf_din;

    logic                       iss_valid;
    logic [N-1:0]               iss_reg;
    logic [(1<<N)-1:0]          pending;

    modport master (
        output req_valid, req_reg, req_data, iss_valid, iss_reg,
        input  req_ready, rf_wenable, rf_reg, rf_din, pending
    );

    modport slave (
        input  req_valid, req_reg, req_data, iss_valid, iss_reg,
        output req_ready, rf_wenable, rf_reg, rf_din, pending
    );
endinterface

// File: rtl/rr_arbiter.sv
// Round-robin grant: the search starts just after the last granted requester and
// the first valid one found wins, so grant is always one-hot or all zero.
module rr_arbiter #(
    parameter  int NREQ = 3,
    localparam int PW   = regfile_pkg::ptr_width(NREQ)
) (
    input  logic [NREQ-1:0] valid,
    input  logic [PW-1:0]   pointer,
    output logic [NREQ-1:0] grant
);
    logic [PW-1:0] idx;

    // Walk from the farthest slot to the nearest so the nearest valid requester overwrites the rest
    always_comb begin
        grant = '0;
        idx   = '0;
        for (int k = NREQ; k >= 1; k--) begin
            idx = PW'((int'(pointer) + k) % NREQ);
            if (valid[idx]) begin
                grant      = '0;
                grant[idx] = 1'b1;
            end
        end
    end
endmodule

// File: rtl/regfile_wb_arbiter.sv
// Writeback arbiter: one round-robin winner per cycle is registered onto the
// register-file write port, and a scoreboard tracks registers with writes outstanding.
module regfile_wb_arbiter #(
    parameter int N     = regfile_pkg::N,
    parameter int WIDTH = regfile_pkg::WIDTH,
    parameter int NREQ  = regfile_pkg::NREQ
) (
    input  logic                clk,
    input  logic                rst,
    regfile_wb_arbiter_if.slave bus
);
    import regfile_pkg::*;

    localparam int PW = ptr_width(NREQ);

    logic [PW-1:0]      pointer;
    logic [NREQ-1:0]    grant;
    logic               xfer;
    logic [PW-1:0]      grant_idx;
    logic [N-1:0]       sel_reg;
    logic [WIDTH-1:0]   sel_data;

    logic               rf_wenable_q;
    logic [N-1:0]       rf_reg_q;
    logic [WIDTH-1:0]   rf_din_q;
    logic [(1<<N)-1:0]  pending_q;
    logic [(1<<N)-1:0]  pending_next;

    rr_arbiter #(.NREQ(NREQ)) u_rr_arbiter (
        .valid   (bus.req_valid),
        .pointer (pointer),
        .grant   (grant)
    );

    // Grants are suppressed during reset so nothing can transfer while state is held clear
    assign bus.req_ready = grant & {NREQ{rst}};
    assign xfer          = rst & (|grant);

    always_comb begin
        grant_idx = '0;
        sel_reg   = '0;
        sel_data  = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (grant[i]) begin
                grant_idx = PW'(i);
                sel_reg   = bus.req_reg[i];
                sel_data  = bus.req_data[i];
            end
        end
    end

    // Pointer starts at the last slot so requester 0 is searched first after reset
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pointer <= PW'(NREQ - 1);
        end else if (xfer) begin
            pointer <= grant_idx;
        end
    end

    // Register 0 is hardwired, so a transfer to it is accepted but never written
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rf_wenable_q <= 1'b0;
            rf_reg_q     <= '0;
            rf_din_q     <= '0;
        end else begin
            rf_wenable_q <= xfer && (sel_reg != '0);
            if (xfer) begin
                rf_reg_q <= sel_reg;
                rf_din_q <= sel_data;
            end
        end
    end

    // Set is applied after clear so a same-cycle reissue leaves the newer producer outstanding
    always_comb begin
        pending_next = pending_q;
        if (rf_wenable_q) begin
            pending_next[rf_reg_q] = 1'b0;
        end
        if (bus.iss_valid && (bus.iss_reg != '0)) begin
            pending_next[bus.iss_reg] = 1'b1;
        end
        pending_next[0] = 1'b0;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pending_q <= '0;
        end else begin
            pending_q <= pending_next;
        end
    end

    assign bus.rf_wenable = rf_wenable_q;
    assign bus.rf_reg     = rf_reg_q;
    assign bus.rf_din     = rf_din_q;
    assign bus.pending    = pending_q;
endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Directed and randomized bench for regfile_wb_arbiter against a cycle-level
// behavioural model of grants, write-port timing and the pending scoreboard.
module tb_regfile_wb_arbiter;
    import regfile_pkg::*;

    localparam int NR = 1 << N;

    logic clk;
    logic rst;

    regfile_wb_arbiter_if #(.N(N), .WIDTH(WIDTH), .NREQ(NREQ)) bus ();

    regfile_wb_arbiter #(.N(N), .WIDTH(WIDTH), .NREQ(NREQ)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int checks = 0;
    int errors = 0;

    int              m_last;
    bit              m_wen;
    reg_addr_t       m_reg;
    reg_data_t       m_din;
    logic [NR-1:0]   m_pend;
    reg_data_t       model_rf [NR];
    reg_data_t       dut_rf   [NR];
    logic [NREQ-1:0] obs_ready;
    logic            obs_wen;
    logic [NR-1:0]   pend_before;
    reg_data_t       d1;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_output(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    task automatic model_reset();
        m_last = NREQ - 1;
        m_wen  = 1'b0;
        m_reg  = '0;
        m_din  = '0;
        m_pend = '0;
    endtask

    // Next requester at or after last grant + 1, modulo NREQ; -1 when nobody is valid
    function automatic int exp_grant();
        for (int k = 1; k <= NREQ; k++) begin
            if (bus.req_valid[(m_last + k) % NREQ]) return (m_last + k) % NREQ;
        end
        return -1;
    endfunction

    task automatic check_state();
        int g;
        logic [NREQ-1:0] er;
        g  = exp_grant();
        er = '0;
        if (g >= 0) er[g] = 1'b1;
        obs_ready = bus.req_ready;
        obs_wen   = bus.rf_wenable;
        check_output("req_ready", 64'(bus.req_ready), 64'(er));
        check_output("rf_wenable", 64'(bus.rf_wenable), 64'(m_wen));
        if (m_wen) begin
            check_output("rf_reg", 64'(bus.rf_reg), 64'(m_reg));
            check_output("rf_din", 64'(bus.rf_din), 64'(m_din));
            model_rf[m_reg] = m_din;
        end
        check_output("pending", 64'(bus.pending), 64'(m_pend));
        if (bus.rf_wenable === 1'b1) dut_rf[bus.rf_reg] = bus.rf_din;
    endtask

    task automatic model_step();
        int g;
        logic [NR-1:0] nxt;
        g   = exp_grant();
        nxt = m_pend;
        if (m_wen) nxt[m_reg] = 1'b0;
        if (bus.iss_valid && bus.iss_reg != 0) nxt[bus.iss_reg] = 1'b1;
        m_pend = nxt;
        if (g >= 0) begin
            m_last = g;
            m_wen  = (bus.req_reg[g] != 0);
            m_reg  = bus.req_reg[g];
            m_din  = bus.req_data[g];
        end else begin
            m_wen = 1'b0;
        end
    endtask

    task automatic step();
        @(negedge clk);
        check_state();
        model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_stimulus(input int i, input logic v, input reg_addr_t r, input reg_data_t d);
        bus.req_valid[i] = v;
        bus.req_reg[i]   = r;
        bus.req_data[i]  = d;
    endtask

    task automatic drop_granted();
        for (int i = 0; i < NREQ; i++) begin
            if (obs_ready[i] === 1'b1) bus.req_valid[i] = 1'b0;
        end
    endtask

    task automatic drain();
        for (int n = 0; n < 8 && bus.req_valid != '0; n++) begin
            step();
            drop_granted();
        end
        check_output("drain", 64'(bus.req_valid), 64'd0);
        bus.req_valid = '0;
        step();
        step();
    endtask

    initial begin
        rst           = 1'b0;
        bus.req_valid = '0;
        bus.req_reg   = '0;
        bus.req_data  = '0;
        bus.iss_valid = 1'b0;
        bus.iss_reg   = '0;
        model_reset();
        for (int r = 0; r < NR; r++) begin
            model_rf[r] = '0;
            dut_rf[r]   = '0;
        end

        // Reset: outputs clear and no grant even with every requester valid
        for (int i = 0; i < NREQ; i++) apply_stimulus(i, 1'b1, reg_addr_t'(i + 1), $urandom());
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_output("rst_wen", 64'(bus.rf_wenable), 64'd0);
        check_output("rst_reg", 64'(bus.rf_reg), 64'd0);
        check_output("rst_din", 64'(bus.rf_din), 64'd0);
        check_output("rst_pending", 64'(bus.pending), 64'd0);
        check_output("rst_ready", 64'(bus.req_ready), 64'd0);
        @(posedge clk);
        #1;
        rst = 1'b1;

        // Three requesters to regs 1,2,3 are served in order 0,1,2
        step();
        check_output("g032_0", 64'(obs_ready), 64'b001);
        check_output("w032_reg1", 64'(bus.rf_reg), 64'd1);
        drop_granted();
        step();
        check_output("g032_1", 64'(obs_ready), 64'b010);
        check_output("w032_wen", 64'(obs_wen), 64'd1);
        drop_granted();
        step();
        check_output("g032_2", 64'(obs_ready), 64'b100);
        check_output("w032_reg3", 64'(bus.rf_reg), 64'd3);
        drop_granted();
        step();
        step();

        // Lone requester 1 streams every cycle, then requester 2 is next in line
        apply_stimulus(1, 1'b1, 5'd7, $urandom());
        for (int k = 0; k < 4; k++) begin
            step();
            check_output("g033_solo", 64'(obs_ready), 64'b010);
            apply_stimulus(1, 1'b1, 5'd7, $urandom());
        end
        apply_stimulus(0, 1'b1, 5'd8, $urandom());
        apply_stimulus(2, 1'b1, 5'd9, $urandom());
        step();
        check_output("g033_next", 64'(obs_ready), 64'b100);
        drop_granted();
        drain();

        // Write to register 0 is accepted but never reaches the write port
        pend_before = m_pend;
        apply_stimulus(0, 1'b1, 5'd0, 32'hDEADBEEF);
        step();
        check_output("g034", 64'(obs_ready), 64'b001);
        drop_granted();
        step();
        check_output("w034_wen", 64'(obs_wen), 64'd0);
        check_output("p034", 64'(bus.pending), 64'(pend_before));

        // Scoreboard: set on issue, clear on the write cycle, same-cycle reissue keeps it set
        bus.iss_valid = 1'b1;
        bus.iss_reg   = 5'd5;
        step();
        bus.iss_valid = 1'b0;
        check_output("p035_set", 64'(bus.pending[5]), 64'd1);
        apply_stimulus(2, 1'b1, 5'd5, $urandom());
        step();
        drop_granted();
        check_output("w035_wen", 64'(bus.rf_wenable), 64'd1);
        check_output("p035_during", 64'(bus.pending[5]), 64'd1);
        step();
        check_output("p035_clear", 64'(bus.pending[5]), 64'd0);
        apply_stimulus(2, 1'b1, 5'd5, $urandom());
        step();
        drop_granted();
        bus.iss_valid = 1'b1;
        bus.iss_reg   = 5'd5;
        step();
        bus.iss_valid = 1'b0;
        check_output("p035_reissue", 64'(bus.pending[5]), 64'd1);

        // Same destination from two requesters: grant order 0 then 1, last write wins
        d1 = $urandom();
        apply_stimulus(0, 1'b1, 5'd10, $urandom());
        apply_stimulus(1, 1'b1, 5'd10, d1);
        step();
        drop_granted();
        step();
        drop_granted();
        step();
        step();
        check_output("rf024_last", 64'(dut_rf[10]), 64'(d1));

        // Asynchronous reset in the middle of a write cycle
        apply_stimulus(0, 1'b1, 5'd3, $urandom());
        bus.iss_valid = 1'b1;
        bus.iss_reg   = 5'd2;
        step();
        bus.iss_valid = 1'b0;
        drop_granted();
        check_output("w036_wen", 64'(bus.rf_wenable), 64'd1);
        check_output("p036_before", 64'(bus.pending), 64'h24);
        for (int i = 0; i < NREQ; i++) apply_stimulus(i, 1'b1, reg_addr_t'(11 + i), $urandom());
        rst = 1'b0;
        #1;
        check_output("r036_wen", 64'(bus.rf_wenable), 64'd0);
        check_output("r036_reg", 64'(bus.rf_reg), 64'd0);
        check_output("r036_din", 64'(bus.rf_din), 64'd0);
        check_output("r036_pending", 64'(bus.pending), 64'd0);
        check_output("r036_ready", 64'(bus.req_ready), 64'd0);
        model_reset();
        @(posedge clk);
        #1;
        rst = 1'b1;
        step();
        check_output("g036_first", 64'(obs_ready), 64'b001);
        drop_granted();
        drain();

        // Randomized traffic with register collisions, register 0 and issue marks
        for (int n = 0; n < 300; n++) begin
            for (int i = 0; i < NREQ; i++) begin
                if (bus.req_valid[i] == 1'b0 && $urandom_range(0, 1) == 1)
                    apply_stimulus(i, 1'b1, reg_addr_t'($urandom_range(0, 7)), $urandom());
            end
            bus.iss_valid = ($urandom_range(0, 2) == 0);
            bus.iss_reg   = reg_addr_t'($urandom_range(0, 7));
            step();
            drop_granted();
        end
        bus.iss_valid = 1'b0;
        drain();

        for (int r = 1; r < NR; r++) begin
            check_output($sformatf("rf%0d", r), 64'(dut_rf[r]), 64'(model_rf[r]));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
